// File: rtl/mat_wr_pkg.sv
// Shared types for the matrix write controller: FSM state encoding and address type.
// Optional column-major placement is enabled with MAT_WR_TRANSPOSE_EN.
package mat_wr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } mat_wr_state_t;

  localparam int MAT_WR_ADDR_W = 11;

  typedef logic [MAT_WR_ADDR_W-1:0] mat_wr_addr_t;

endpackage

// File: rtl/mat_addr_gen.sv
// Incremental RAM address generator for matrix placement (no multipliers).
// Column-major stepping is built only when MAT_WR_TRANSPOSE_EN is defined.
module mat_addr_gen
  import mat_wr_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DIM_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] base,
  input  logic [DIM_W-1:0]  rows,
  input  logic [DIM_W-1:0]  cols,
  input  logic              transpose,
  input  logic              init,
  input  logic              step,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] addr_reg;

`ifdef MAT_WR_TRANSPOSE_EN
  logic [ADDR_W-1:0] row_start_reg;
  logic [ADDR_W-1:0] stride_reg;
  logic [DIM_W-1:0]  col_reg;
  logic [DIM_W-1:0]  last_col_reg;
  logic              tr_reg;

  // Column-major: walk one row with stride 'rows', then restart at the next row start.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg      <= '0;
      row_start_reg <= '0;
      stride_reg    <= '0;
      col_reg       <= '0;
      last_col_reg  <= '0;
      tr_reg        <= 1'b0;
    end else if (init) begin
      addr_reg      <= base;
      row_start_reg <= base;
      stride_reg    <= ADDR_W'(rows);
      col_reg       <= '0;
      last_col_reg  <= cols - DIM_W'(1);
      tr_reg        <= transpose;
    end else if (step) begin
      if (!tr_reg) begin
        addr_reg <= addr_reg + ADDR_W'(1);
      end else if (col_reg == last_col_reg) begin
        col_reg       <= '0;
        row_start_reg <= row_start_reg + ADDR_W'(1);
        addr_reg      <= row_start_reg + ADDR_W'(1);
      end else begin
        col_reg  <= col_reg + DIM_W'(1);
        addr_reg <= addr_reg + stride_reg;
      end
    end
  end
`else
  // Row-major address of element k is simply base + k.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg <= '0;
    end else if (init) begin
      addr_reg <= base;
    end else if (step) begin
      addr_reg <= addr_reg + ADDR_W'(1);
    end
  end

  logic unused_shape;
  assign unused_shape = ^{rows, cols, transpose};
`endif

  assign addr = addr_reg;

endmodule

// File: rtl/mat_write_controller.sv
// Streams matrix elements into a RAM write port at row-major (or, with
// MAT_WR_TRANSPOSE_EN defined, column-major) addresses, with short/overflow flags.
module mat_write_controller
  import mat_wr_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11,
  parameter int DIM_W  = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [DIM_W-1:0]         rows,
  input  logic [DIM_W-1:0]         cols,
  input  logic                     transpose,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_last,
  output logic                     ram_wr_en,
  output logic [ADDR_W-1:0]        ram_wr_addr,
  output logic [DATA_W-1:0]        ram_wr_data,
  output logic [2*DIM_W-1:0]       write_count,
  output logic                     busy,
  output logic                     done,
  output logic                     err_short,
  output logic                     err_overflow
);

  localparam int CNT_W = 2 * DIM_W;

  mat_wr_state_t     state_reg, state_next;
  logic [CNT_W-1:0]  total_reg, count_reg;
  logic [ADDR_W-1:0] gen_addr;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [DATA_W-1:0] wr_data_reg;
  logic              wr_en_reg, short_reg, overflow_reg;
  logic              start_acc, accept, final_acc, zero_dim;

  assign start_acc = (state_reg == IDLE) && start;
  assign zero_dim  = (rows == '0) || (cols == '0);
  assign accept    = in_valid && (state_reg == WRITE);
  // in_last before the Nth element ends the job early.
  assign final_acc = accept && (in_last || ((count_reg + CNT_W'(1)) == total_reg));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = zero_dim ? DONE : WRITE;
      WRITE:   if (final_acc) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_reg == WRITE);
    busy     = (state_reg != IDLE);
    done     = (state_reg == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_reg    <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
      total_reg    <= '0;
      count_reg    <= '0;
      short_reg    <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      wr_en_reg <= accept;
      if (accept) begin
        wr_addr_reg <= gen_addr;
        wr_data_reg <= in_data;
      end
      if (start_acc) begin
        total_reg    <= CNT_W'(rows) * CNT_W'(cols);
        count_reg    <= '0;
        short_reg    <= 1'b0;
        overflow_reg <= 1'b0;
      end else begin
        if (accept) count_reg <= count_reg + CNT_W'(1);
        if (accept && in_last && ((count_reg + CNT_W'(1)) < total_reg)) short_reg <= 1'b1;
        if (in_valid && (state_reg != WRITE)) overflow_reg <= 1'b1;
      end
    end
  end

  mat_addr_gen #(
    .ADDR_W(ADDR_W),
    .DIM_W (DIM_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .base     (base_addr),
    .rows     (rows),
    .cols     (cols),
    .transpose(transpose),
    .init     (start_acc),
    .step     (accept),
    .addr     (gen_addr)
  );

  assign ram_wr_en    = wr_en_reg;
  assign ram_wr_addr  = wr_addr_reg;
  assign ram_wr_data  = wr_data_reg;
  assign write_count  = count_reg;
  assign err_short    = short_reg;
  assign err_overflow = overflow_reg;

endmodule

// File: tb/tb_mat_write_controller.sv
// Directed bench for mat_write_controller: table of jobs plus overflow and reset sequences.
// Expected transpose addresses follow MAT_WR_TRANSPOSE_EN.
module tb_mat_write_controller;
  import mat_wr_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 11;
  localparam int DIM_W  = 6;

  logic                     clk = 1'b0;
  logic                     rst, start, transpose, in_valid, in_last;
  logic [ADDR_W-1:0]        base_addr;
  logic [DIM_W-1:0]         rows, cols;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_ready, ram_wr_en, busy, done, err_short, err_overflow;
  logic [ADDR_W-1:0]        ram_wr_addr;
  logic [DATA_W-1:0]        ram_wr_data;
  logic [2*DIM_W-1:0]       write_count;

  mat_write_controller #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .rows(rows),
    .cols(cols), .transpose(transpose), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .ram_wr_en(ram_wr_en),
    .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data), .write_count(write_count),
    .busy(busy), .done(done), .err_short(err_short), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    mat_wr_addr_t           base;
    logic [5:0]             rows;
    logic [5:0]             cols;
    logic                   tr;
    logic [3:0]             n_send;
    logic [3:0]             last_idx;
    logic [3:0]             exp_wr;
    logic                   exp_short;
    mat_wr_addr_t [7:0]     exp_addr;
  } vec_t;

  vec_t vecs[6];
  int   n_vec  = 0;
  int   n_miss = 0;

  mat_wr_addr_t wr_addr_q[$];
  logic [31:0]  wr_data_q[$];
  int           done_cnt, done_no_wr;

  always @(negedge clk) begin
    if (ram_wr_en) begin
      wr_addr_q.push_back(ram_wr_addr);
      wr_data_q.push_back(ram_wr_data);
    end
    if (done) begin
      done_cnt++;
      if (!ram_wr_en) done_no_wr++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int base, input int r, input int c, input bit tr,
                              input int n, input int last, input int exp_wr, input bit shrt);
    vec_t v;
    v.base = mat_wr_addr_t'(base);
    v.rows = 6'(r);
    v.cols = 6'(c);
    v.tr = tr;
    v.n_send = 4'(n);
    v.last_idx = 4'(last);
    v.exp_wr = 4'(exp_wr);
    v.exp_short = shrt;
    for (int i = 0; i < 8; i++) v.exp_addr[i] = mat_wr_addr_t'(base + i);
    return v;
  endfunction

  task automatic wait_ready(input string name);
    int t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s_ready: got in_ready=0 after 20 cycles, expected 1", name);
    end
  endtask

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cnt = 0;
    done_no_wr = 0;
  endtask

  task automatic run_job(input vec_t v, input int vi);
    string nm;
    nm = $sformatf("v%0d", vi);
    clear_mon();
    base_addr = v.base; rows = v.rows; cols = v.cols; transpose = v.tr; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < int'(v.n_send); k++) begin
      in_valid = 1'b1;
      in_data  = 32'(vi * 16 + 10 + k);
      in_last  = (k == int'(v.last_idx));
      wait_ready(nm);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (3) @(negedge clk);
    chk({nm, "_nwr"}, 32'(wr_addr_q.size()), 32'(v.exp_wr));
    for (int i = 0; i < int'(v.exp_wr); i++) begin
      if (i < wr_addr_q.size()) begin
        chk($sformatf("%s_addr%0d", nm, i), 32'(wr_addr_q[i]), 32'(v.exp_addr[i]));
        chk($sformatf("%s_data%0d", nm, i), wr_data_q[i], 32'(vi * 16 + 10 + i));
      end
    end
    chk({nm, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({nm, "_done_no_wr"}, 32'(done_no_wr), (v.exp_wr == 0) ? 32'd1 : 32'd0);
    chk({nm, "_count"}, 32'(write_count), 32'(v.exp_wr));
    chk({nm, "_short"}, 32'(err_short), 32'(v.exp_short));
    chk({nm, "_ovf"}, 32'(err_overflow), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    $display("job v%0d: base=%0d rows=%0d cols=%0d tr=%0b writes=%0d count=%0d short=%0b",
             vi, v.base, v.rows, v.cols, v.tr, wr_addr_q.size(), write_count, err_short);
  endtask

  initial begin
    vecs[0] = mk(0,    2, 3, 1'b0, 6, 15, 6, 1'b0);
    vecs[1] = mk(20,   3, 3, 1'b0, 5, 4,  5, 1'b1);
    vecs[2] = mk(2046, 1, 4, 1'b0, 4, 15, 4, 1'b0);
    vecs[3] = mk(100,  2, 3, 1'b1, 6, 5,  6, 1'b0);
    vecs[4] = mk(7,    0, 5, 1'b0, 0, 15, 0, 1'b0);
    vecs[5] = mk(300,  2, 2, 1'b0, 4, 3,  4, 1'b0);
`ifdef MAT_WR_TRANSPOSE_EN
    vecs[3].exp_addr[0] = 11'd100; vecs[3].exp_addr[1] = 11'd102;
    vecs[3].exp_addr[2] = 11'd104; vecs[3].exp_addr[3] = 11'd101;
    vecs[3].exp_addr[4] = 11'd103; vecs[3].exp_addr[5] = 11'd105;
`endif

    rst = 1'b1; start = 1'b0; transpose = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    base_addr = '0; rows = '0; cols = '0; in_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_wr_en", 32'(ram_wr_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_count", 32'(write_count), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_job(vecs[i], i);

    // Element beyond a finished 2x3 job: must never be written and must flag overflow.
    run_job(vecs[0], 0);
    clear_mon();
    in_valid = 1'b1; in_data = 32'd99;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("ovf_nwr", 32'(wr_addr_q.size()), 0);
    chk("ovf_flag", 32'(err_overflow), 1);
    repeat (3) @(negedge clk);
    chk("ovf_sticky", 32'(err_overflow), 1);
    base_addr = 11'd5; rows = 6'd1; cols = 6'd1; transpose = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ovf_clear", 32'(err_overflow), 0);
    chk("ovf_busy", 32'(busy), 1);
    in_valid = 1'b1; in_data = 32'd77;
    wait_ready("ovf");
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("ovf_job_nwr", 32'(wr_addr_q.size()), 1);
    if (wr_addr_q.size() > 0) chk("ovf_job_addr", 32'(wr_addr_q[0]), 5);
    $display("seq overflow: writes=%0d err_overflow=%0b", wr_addr_q.size(), err_overflow);

    // Reset after two of six writes: job abandoned, no done, no later writes.
    clear_mon();
    base_addr = 11'd40; rows = 6'd2; cols = 6'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_data = 32'(200 + k);
      wait_ready("rst");
      @(negedge clk);
    end
    in_data = 32'd202;
    rst = 1'b1;
    @(negedge clk);
    chk("rstj_ready", 32'(in_ready), 0);
    chk("rstj_wr_en", 32'(ram_wr_en), 0);
    chk("rstj_addr", 32'(ram_wr_addr), 0);
    chk("rstj_data", ram_wr_data, 0);
    chk("rstj_count", 32'(write_count), 0);
    chk("rstj_busy", 32'(busy), 0);
    chk("rstj_done", 32'(done), 0);
    chk("rstj_short", 32'(err_short), 0);
    chk("rstj_ovf", 32'(err_overflow), 0);
    in_valid = 1'b0;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rstj_nwr", 32'(wr_addr_q.size()), 2);
    chk("rstj_done_cnt", 32'(done_cnt), 0);
    $display("seq reset: writes=%0d done_pulses=%0d", wr_addr_q.size(), done_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mat_write_controller.md
MAT_WRITE_CONTROLLER -- requirements
Module: mat_write_controller

Interface
REQ-001 SHALL have parameter DATA_W, default 32, RAM data / element width in bits.
REQ-002 SHALL have parameter ADDR_W, default 11, RAM address width in bits.
REQ-003 SHALL have parameter DIM_W, default 6, width of the row and column dimension inputs.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port start  input  1  one-cycle pulse; captures base_addr, rows, cols and transpose.
REQ-007 SHALL have ports base_addr  input  ADDR_W, rows  input  DIM_W, cols  input  DIM_W  matrix placement and shape.
REQ-008 SHALL have port transpose  input  1  column-major placement request.
REQ-009 SHALL have ports in_data  input  DATA_W (signed), in_valid  input  1, in_ready  output  1  element stream handshake.
REQ-010 SHALL have port in_last  input  1  qualified by in_valid; parser marks final element.
REQ-011 SHALL have ports ram_wr_en  output  1, ram_wr_addr  output  ADDR_W, ram_wr_data  output  DATA_W  RAM write port.
REQ-012 SHALL have ports write_count  output  2*DIM_W, busy  output  1, done  output  1 (pulse), err_short  output  1, err_overflow  output  1 (sticky).

Function
REQ-013 SHALL implement states IDLE, WRITE, DONE; IDLE->WRITE on start, WRITE->DONE on final accepted element, DONE->IDLE after one cycle.
REQ-014 SHALL compute expected count N = rows*cols at start, full 2*DIM_W width, no truncation.
REQ-015 SHALL go directly IDLE->DONE with done pulse and zero writes when start arrives with rows==0 or cols==0.
REQ-016 SHALL assert in_ready only in WRITE; an element is accepted when in_valid && in_ready.
REQ-017 SHALL register each accepted element: ram_wr_en high, ram_wr_addr and ram_wr_data valid exactly one cycle after acceptance; ram_wr_en low otherwise.
REQ-018 SHALL address row-major by default: element k (input order r,c) at base_addr + r*cols + c, computed incrementally without multipliers in the datapath.
REQ-019 SHALL wrap addresses modulo 2^ADDR_W silently.
REQ-020 SHALL increment write_count per accepted element and hold it until the next start.
REQ-021 SHALL finish on the Nth accepted element regardless of in_last; in_last on that element is normal.
REQ-022 SHALL, on in_last accepted with write_count+1 < N, write that element, set err_short for the job, and finish.
REQ-023 SHALL set err_overflow when in_valid is high in IDLE or DONE (elements beyond N); such data is never written.
REQ-024 SHALL pulse done one cycle, in DONE, coincident with the final ram_wr_en; busy high in WRITE and DONE.
REQ-025 SHALL ignore start while busy; err_short and err_overflow clear on an accepted start.

Reset
REQ-026 SHALL on rst force state IDLE, in_ready 0, ram_wr_en 0, ram_wr_addr 0, ram_wr_data 0, write_count 0, busy 0, done 0, err_short 0, err_overflow 0.
REQ-027 SHALL abandon a job on rst mid-WRITE with no further writes and no done pulse.

Configuration
REQ-028 SHALL, with macro MAT_WR_TRANSPOSE_EN defined, honour transpose=1: element (r,c) at base_addr + c*rows + r, via a row-start pointer plus stride rows.
REQ-029 SHALL, without MAT_WR_TRANSPOSE_EN, keep the transpose port but ignore it, always row-major, with no transpose logic synthesised.

Structure
REQ-030 SHALL take the state enum and a mat_wr_addr_t typedef from shared package mat_wr_pkg.
REQ-031 SHALL place address generation in sub-module mat_addr_gen (inputs base, rows, cols, transpose, init, step; output addr).

Verification
REQ-032 SHALL check: base 0, rows 2, cols 3, six elements 10..15 with in_valid held -> writes to addresses 0..5 in order, done with 6th write, write_count 6.
REQ-033 SHALL check (macro defined): base 100, rows 2, cols 3, transpose 1, elements 0..5 -> addresses 100,102,104,101,103,105.
REQ-034 SHALL check: rows 3, cols 3, in_last on 5th element -> 5 writes, err_short 1, done pulses, write_count 5.
REQ-035 SHALL check: base 2046, ADDR_W 11, rows 1, cols 4 -> addresses 2046, 2047, 0, 1.
REQ-036 SHALL check: 7th element presented after a 2x3 job -> no write, err_overflow 1 until next start.
REQ-037 SHALL check: rst asserted after 2 of 6 writes -> all outputs at reset values next cycle, no done, no further ram_wr_en.
